// File: rtl/esp32_boot_pkg.sv
// Shared types and constants for the ESP32 boot/strap sequencer.
package esp32_boot_pkg;

    localparam int unsigned CntWidth         = 24;
    localparam int unsigned DefEnLowTime     = 2500000;
    localparam int unsigned DefStrapHoldTime = 1250000;

    typedef logic [CntWidth-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StEnLow,
        StStrapHold,
        StDone
    } boot_state_e;

endpackage

// File: rtl/esp32_boot_sequencer_if.sv
// Request/status and ESP32 pin-drive signals of the boot sequencer.
interface esp32_boot_sequencer_if;

    logic req;
    logic req_boot;
    logic busy;
    logic done;
    logic wifi_en;
    logic wifi_gpio0_o;
    logic wifi_gpio2_o;
    logic wifi_strap_oe;

    modport master (
        output req, req_boot,
        input  busy, done, wifi_en, wifi_gpio0_o, wifi_gpio2_o, wifi_strap_oe
    );

    modport slave (
        input  req, req_boot,
        output busy, done, wifi_en, wifi_gpio0_o, wifi_gpio2_o, wifi_strap_oe
    );

endinterface

// File: rtl/esp32_boot_timer.sv
// Loadable 24-bit down counter with zero flag; saturates at zero.
module esp32_boot_timer
    import esp32_boot_pkg::*;
(
    input  logic clk_25mhz,
    input  logic rstn,
    input  logic load,
    input  cnt_t load_val,
    input  logic dec,
    output logic zero
);

    cnt_t cnt_q;

    always_ff @(posedge clk_25mhz) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - cnt_t'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Drives ESP32 EN low, holds GPIO0/GPIO2 straps across the EN rising edge, then releases them.
module esp32_boot_sequencer
    import esp32_boot_pkg::*;
#(
    parameter int unsigned C_en_low_time      = DefEnLowTime,
    parameter int unsigned C_strap_hold_time  = DefStrapHoldTime,
    parameter int unsigned C_powerup_sequence = 0
) (
    input  logic                         clk_25mhz,
    input  logic                         rstn,
    esp32_boot_sequencer_if.slave        bus
);

    localparam cnt_t EnLowLoad = cnt_t'(C_en_low_time - 1);
    localparam cnt_t StrapLoad = cnt_t'(C_strap_hold_time - 1);
    localparam bit   PowerUp   = (C_powerup_sequence != 0);

    boot_state_e state_q, state_d;
    logic        mode_q, mode_d;
    logic        pwr_q, pwr_d;
    logic        load, dec, zero;
    cnt_t        load_val;

    logic busy_d, done_d, en_d, oe_d, gpio_d;
    logic busy_q, done_q, en_q, oe_q, gpio_q;

    esp32_boot_timer u_timer (
        .clk_25mhz (clk_25mhz),
        .rstn      (rstn),
        .load      (load),
        .load_val  (load_val),
        .dec       (dec),
        .zero      (zero)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pwr_d    = pwr_q;
        load     = 1'b0;
        dec      = 1'b0;
        load_val = EnLowLoad;
        unique case (state_q)
            StIdle: begin
                // Pending power-up start wins and forces normal mode.
                if (pwr_q || bus.req) begin
                    mode_d  = pwr_q ? 1'b0 : bus.req_boot;
                    pwr_d   = 1'b0;
                    load    = 1'b1;
                    state_d = StEnLow;
                end
            end
            StEnLow: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = StrapLoad;
                    state_d  = StStrapHold;
                end else begin
                    dec = 1'b1;
                end
            end
            StStrapHold: begin
                if (zero) state_d = StDone;
                else      dec     = 1'b1;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        busy_d = (state_d == StEnLow) || (state_d == StStrapHold);
        done_d = (state_d == StDone);
        en_d   = (state_d != StEnLow);
        oe_d   = busy_d;
        gpio_d = busy_d ? ~mode_d : 1'b1;
    end

    always_ff @(posedge clk_25mhz) begin
        if (!rstn) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            pwr_q   <= PowerUp;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b1;
            oe_q    <= 1'b0;
            gpio_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pwr_q   <= pwr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            oe_q    <= oe_d;
            gpio_q  <= gpio_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.wifi_en       = en_q;
    assign bus.wifi_strap_oe = oe_q;
    assign bus.wifi_gpio0_o  = gpio_q;
    assign bus.wifi_gpio2_o  = gpio_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Directed scoreboard bench: expected per-cycle pin patterns are queued, then popped each clock.
module tb_esp32_boot_sequencer;

    logic clk_25mhz = 1'b0;
    logic rstn      = 1'b0;
    logic rstn_pu   = 1'b0;
    logic sel       = 1'b0;

    always #20 clk_25mhz = ~clk_25mhz;

    esp32_boot_sequencer_if bus ();
    esp32_boot_sequencer_if bus_pu ();

    esp32_boot_sequencer #(
        .C_en_low_time      (4),
        .C_strap_hold_time  (6),
        .C_powerup_sequence (0)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .rstn      (rstn),
        .bus       (bus.slave)
    );

    esp32_boot_sequencer #(
        .C_en_low_time      (4),
        .C_strap_hold_time  (6),
        .C_powerup_sequence (1)
    ) dut_pu (
        .clk_25mhz (clk_25mhz),
        .rstn      (rstn_pu),
        .bus       (bus_pu.slave)
    );

    // Entry = {mask, value}; bits {busy, done, wifi_en, oe, gpio0, gpio2}
    logic [11:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] Idle = 6'b001011;
    localparam logic [5:0] Full = 6'b111111;

    task automatic push(input logic [5:0] val, input logic [5:0] mask, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({mask, val});
    endtask

    task automatic push_idle(input int n);
        push(Idle, Full, n);
    endtask

    task automatic push_seq(input logic mode);
        push({4'b1001, ~mode, ~mode}, Full, 4);
        push({4'b1011, ~mode, ~mode}, Full, 6);
        push(6'b011000, 6'b111100, 1);
    endtask

    task automatic tick(input string tag);
        logic [11:0] e;
        logic [5:0]  obs;
        @(posedge clk_25mhz);
        #1;
        if (sel) obs = {bus_pu.busy, bus_pu.done, bus_pu.wifi_en, bus_pu.wifi_strap_oe,
                        bus_pu.wifi_gpio0_o, bus_pu.wifi_gpio2_o};
        else     obs = {bus.busy, bus.done, bus.wifi_en, bus.wifi_strap_oe,
                        bus.wifi_gpio0_o, bus.wifi_gpio2_o};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty obs=%b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert ((obs & e[11:6]) === (e[5:0] & e[11:6])) else begin
                failures++;
                $error("FAIL %s obs=%b exp=%b mask=%b", tag, obs, e[5:0], e[11:6]);
            end
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) tick(tag);
    endtask

    initial begin
        bus.req       = 1'b0;
        bus.req_boot  = 1'b0;
        bus_pu.req      = 1'b0;
        bus_pu.req_boot = 1'b0;

        // Reset values
        push_idle(2);
        drain("reset");
        #1 rstn = 1'b1;
        push_idle(2);
        drain("idle");

        // Download-mode sequence
        bus.req = 1'b1; bus.req_boot = 1'b1;
        push_seq(1'b1);
        tick("dl_seq");
        bus.req = 1'b0; bus.req_boot = 1'b0;
        drain("dl_seq");
        push_idle(2);
        drain("dl_after");

        // Normal-mode sequence
        bus.req = 1'b1; bus.req_boot = 1'b0;
        push_seq(1'b0);
        tick("run_seq");
        bus.req = 1'b0;
        drain("run_seq");
        push_idle(2);
        drain("run_after");

        // Request during EN_LOW ignored, mode stays latched
        bus.req = 1'b1; bus.req_boot = 1'b0;
        push_seq(1'b0);
        tick("busy_req");
        bus.req = 1'b0;
        tick("busy_req");
        bus.req = 1'b1; bus.req_boot = 1'b1;
        tick("busy_req");
        bus.req = 1'b0; bus.req_boot = 1'b0;
        drain("busy_req");
        push_idle(4);
        drain("busy_req_after");

        // Held request: back-to-back with one IDLE cycle between
        bus.req = 1'b1; bus.req_boot = 1'b1;
        push_seq(1'b1); push_idle(1);
        push_seq(1'b1); push_idle(1);
        push_seq(1'b1);
        drain("held_req");
        bus.req = 1'b0; bus.req_boot = 1'b0;
        push_idle(3);
        drain("held_after");

        // Reset during STRAP_HOLD cycle 2 aborts without done
        bus.req = 1'b1; bus.req_boot = 1'b1;
        push({4'b1001, 2'b00}, Full, 4);
        push({4'b1011, 2'b00}, Full, 2);
        tick("abort_pre");
        bus.req = 1'b0; bus.req_boot = 1'b0;
        drain("abort_pre");
        rstn = 1'b0;
        push_idle(1);
        tick("abort_rst");
        rstn = 1'b1;
        push_idle(12);
        drain("abort_after");

        // Power-up sequence on the second instance, conflicting req ignored
        sel = 1'b1;
        push_idle(2);
        drain("pu_reset");
        rstn_pu = 1'b1;
        bus_pu.req = 1'b1; bus_pu.req_boot = 1'b1;
        push_seq(1'b0);
        tick("pu_seq");
        bus_pu.req = 1'b0; bus_pu.req_boot = 1'b0;
        drain("pu_seq");
        push_idle(3);
        drain("pu_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esp32_boot_sequencer.md
ESP32_BOOT_SEQUENCER -- requirements
Module: esp32_boot_sequencer

Interface
REQ-001 SHALL have parameter C_en_low_time, default 2500000: wifi_en low cycles (100 ms at 25 MHz); legal range 1..2^24-1.
REQ-002 SHALL have parameter C_strap_hold_time, default 1250000: cycles straps stay driven after wifi_en rises (50 ms); legal range 1..2^24-1.
REQ-003 SHALL have parameter C_powerup_sequence, default 0: 1 = run one normal-mode sequence automatically after reset.
REQ-004 clk_25mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 req  input  1  start request, sampled on every clock edge.
REQ-007 req_boot  input  1  mode, qualified with req: 1 = download (gpio0 low), 0 = normal run (gpio0 high).
REQ-008 busy  output  1  high while a sequence runs.
REQ-009 done  output  1  one-cycle pulse when a sequence completes.
REQ-010 wifi_en  output  1  ESP32 EN drive value (1 = run).
REQ-011 wifi_gpio0_o  output  1  GPIO0 drive value.
REQ-012 wifi_gpio2_o  output  1  GPIO2 drive value; always equal to wifi_gpio0_o.
REQ-013 wifi_strap_oe  output  1  1 = drive gpio0/gpio2; 0 = tri-state (wrapper maps 0 to 1'bz).

Function
REQ-014 SHALL implement FSM with states IDLE, EN_LOW, STRAP_HOLD, DONE.
REQ-015 IDLE: busy=0, wifi_en=1, wifi_strap_oe=0, wifi_gpio0_o=1.
REQ-016 IDLE with req=1 SHALL latch req_boot into mode register, load counter with C_en_low_time-1, go to EN_LOW next cycle.
REQ-017 EN_LOW: wifi_en=0, wifi_strap_oe=1, wifi_gpio0_o=~mode, busy=1; counter decrements each cycle; at counter==0 load C_strap_hold_time-1, go to STRAP_HOLD.
REQ-018 wifi_en SHALL be low for exactly C_en_low_time cycles.
REQ-019 STRAP_HOLD: wifi_en=1, wifi_strap_oe=1, wifi_gpio0_o=~mode, busy=1; at counter==0 go to DONE.
REQ-020 Straps SHALL stay driven exactly C_strap_hold_time cycles after wifi_en rises, so ESP32 samples them on the EN rising edge.
REQ-021 DONE: done=1 for one cycle, wifi_strap_oe=0, busy=0; always go to IDLE next cycle.
REQ-022 req while busy=1 or in DONE SHALL be ignored; it does not queue.
REQ-023 req held high continuously SHALL restart a sequence on the first IDLE cycle after DONE.
REQ-024 req_boot changes mid-sequence SHALL have no effect; only the latched mode is used.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-026 Counter width SHALL be 24 bits, counting down only, with no wrap-around reachable.

Reset
REQ-027 rstn=0 at a clock edge SHALL force IDLE and the IDLE output values, done=0, mode=0, counter=0, aborting any sequence in progress.
REQ-028 With C_powerup_sequence=1, the first cycle after rstn deasserts SHALL start a normal-mode sequence as if req=1, req_boot=0 (one-shot flag, cleared on start).
REQ-029 A req in the first cycle after reset SHALL be ignored while the powerup sequence runs.

Structure
REQ-030 Package esp32_boot_pkg SHALL hold the state enum type, counter width constant (24), and default timing constants.
REQ-031 One sub-module, esp32_boot_timer (loadable 24-bit down counter with zero flag), is natural; the FSM SHALL remain in the top module.

Verification (C_en_low_time=4, C_strap_hold_time=6)
REQ-032 req=1, req_boot=1 for one cycle from IDLE -> wifi_en low 4 cycles, gpio0/gpio2=0 with oe=1 for 10 cycles total, done pulse at cycle 11, then oe=0.
REQ-033 req=1, req_boot=0 -> same timing; gpio0/gpio2=1 throughout oe=1.
REQ-034 Second req pulse at cycle 3 of EN_LOW, req_boot toggled -> ignored; one done pulse only; mode unchanged.
REQ-035 rstn=0 during STRAP_HOLD cycle 2 -> next cycle wifi_en=1, oe=0, busy=0, and no done pulse.
REQ-036 req held high 30 cycles -> back-to-back sequences separated by exactly one IDLE cycle after each DONE.
REQ-037 C_powerup_sequence=1, rstn released -> normal-mode sequence with no req; done pulse 11 cycles after release.
